gen_seq_ctrl: RTL
=================

GEN_SEQ_CTRL -- requirements
Module: gen_seq_ctrl

Interface
REQ-001 Parameter NSEG, default 8, segment-table depth; SHALL be a power of two.
REQ-002 Parameter LENW, default 5, width of the segment length field.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cfg_we  in  1  segment-table write strobe.
REQ-006 cfg_addr  in  log2(NSEG)  table entry to write.
REQ-007 cfg_mode  in  1  mode bit for that entry; driven to the datapath x_i input.
REQ-008 cfg_len  in  LENW  segment length in cycles; 0 SHALL mean 1.
REQ-009 cfg_nseg  in  log2(NSEG)+1  number of segments to run; sampled on start.
REQ-010 seed  in  3  initial datapath state; sampled on start.
REQ-011 start  in  1  run request, one-cycle pulse.
REQ-012 abort  in  1  terminate the run.
REQ-013 q  in  3  datapath present-state outputs {Q2,Q1,Q0}.
REQ-014 y  in  1  datapath output Y.
REQ-015 s  out  3  datapath state inputs {S2,S1,S0}.
REQ-016 x_i  out  1  datapath mode input.
REQ-017 busy  out  1  high in LOAD and RUN.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 seg_idx  out  log2(NSEG)  index of the active segment.
REQ-020 y_count  out  8  count of RUN cycles with y=1.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-022 IDLE: start=1 with cfg_nseg>0 -> LOAD; seed/cfg_nseg captured; seg_idx=0; y_count cleared to 0.
REQ-023 IDLE: start=1 with cfg_nseg=0 -> DONE directly; y_count cleared; no LOAD or RUN cycle.
REQ-024 LOAD lasts exactly 1 cycle: s=captured seed, x_i=mode[0]; then -> RUN.
REQ-025 RUN, every cycle: s SHALL equal q sampled at the previous rising edge, closing the datapath feedback loop; x_i=mode[seg_idx].
REQ-026 Per-segment cycle counter: reset to 0 on segment entry; at count=len-1 with more segments remaining -> seg_idx+1; with none remaining -> DONE.
REQ-027 Total RUN cycles SHALL equal the sum of max(len,1) over segments 0..nseg-1.
REQ-028 DONE lasts 1 cycle: done=1, busy=0; then -> IDLE.
REQ-029 IDLE/DONE: s=0, x_i=0; seg_idx and y_count hold last values.
REQ-030 y_count SHALL increment in RUN cycles with y=1 and saturate at 255.
REQ-031 abort=1 in LOAD or RUN -> IDLE next cycle: no done pulse; y_count held. abort has priority over segment advance.
REQ-032 start SHALL be ignored outside IDLE; abort SHALL be ignored in IDLE and DONE.
REQ-033 cfg_we SHALL write table[cfg_addr]={cfg_mode,cfg_len} only while busy=0; writes while busy SHALL be dropped.
REQ-034 cfg_nseg > NSEG SHALL be clamped to NSEG.

Reset
REQ-035 rst=1 SHALL force IDLE and set s=0, x_i=0, busy=0, done=0, seg_idx=0, y_count=0, and every table entry to mode=0, len=0.
REQ-036 rst asserted mid-run SHALL take priority over abort and start, with no done pulse.

Verification
REQ-037 Table {(1,2),(0,2),(1,2),(0,6),(1,20)}, nseg=5, seed=0, start pulse: busy high 33 cycles, x_i pattern 1x2, 0x2, 1x2, 0x6, 1x20, done once; then busy=0.
REQ-038 RUN with q forced to 3'b101: s=3'b101 on the next cycle. After LOAD with seed=3'b110: s=3'b110 for exactly 1 cycle.
REQ-039 y held at 1 through a 300-cycle run: y_count=255 and stays 255.
REQ-040 abort in cycle 5 of RUN: busy=0 next cycle; done never asserted; a following start runs normally.
REQ-041 cfg_we during RUN: table unchanged and the running sequence unaffected. cfg_len=0 entry: that segment lasts 1 cycle. nseg=0: done pulses 1 cycle after start; busy never asserts.
REQ-042 rst at RUN cycle 10: all outputs 0 next cycle; table reads mode=0, len=0.

Source files
------------

// File: rtl/gen_seq_ctrl.sv
// gen_seq_ctrl: segment-table sequencer that drives an external datapath.
// A run steps through nseg table entries, each {mode, len}; x_i carries the
// active segment's mode and s closes the datapath feedback loop (s <= q).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_we/addr/mode/len segment-table write port (accepted only while idle)
//   cfg_nseg, seed      run length in segments / initial datapath state (on start)
//   start, abort        run request pulse / run termination
//   q, y                datapath present state and output
//   s, x_i              datapath state and mode inputs
//   busy, done          LOAD/RUN indicator, one-cycle completion pulse
//   seg_idx, y_count    active segment, saturating count of RUN cycles with y=1
module gen_seq_ctrl #(
  parameter int NSEG = 8,
  parameter int LENW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(NSEG)-1:0] cfg_addr,
  input  logic                    cfg_mode,
  input  logic [LENW-1:0]         cfg_len,
  input  logic [$clog2(NSEG):0]   cfg_nseg,
  input  logic [2:0]              seed,
  input  logic                    start,
  input  logic                    abort,
  input  logic [2:0]              q,
  input  logic                    y,
  output logic [2:0]              s,
  output logic                    x_i,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NSEG)-1:0] seg_idx,
  output logic [7:0]              y_count
);

  localparam int AW = $clog2(NSEG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [NSEG-1:0] tbl_mode;
  logic [LENW-1:0] tbl_len [NSEG];
  logic [AW:0]     nseg_r;
  logic [LENW-1:0] cnt;

  logic [AW:0]     nseg_clamp;
  logic [LENW-1:0] cur_len;
  logic            seg_last;
  logic [AW:0]     idx_inc;
  logic            more_segs;
  logic [AW-1:0]   next_idx;
  logic [7:0]      y_next;

  always_comb begin
    nseg_clamp = (cfg_nseg > (AW+1)'(NSEG)) ? (AW+1)'(NSEG) : cfg_nseg;
    cur_len    = tbl_len[seg_idx];
    // len=0 behaves as len=1: the segment ends on its first cycle.
    seg_last   = (cur_len == '0) || (cnt == cur_len - LENW'(1));
    idx_inc    = {1'b0, seg_idx} + (AW+1)'(1);
    more_segs  = idx_inc < nseg_r;
    next_idx   = seg_idx + AW'(1);
    y_next     = (y_count == '1) ? y_count : y_count + 8'd1;
  end

  // Segment table; writes are dropped while a run is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_mode <= '0;
      for (int unsigned i = 0; i < NSEG; i++) tbl_len[i] <= '0;
    end else if (cfg_we && !busy) begin
      tbl_mode[cfg_addr] <= cfg_mode;
      tbl_len[cfg_addr]  <= cfg_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      x_i     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_idx <= '0;
      y_count <= '0;
      nseg_r  <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            y_count <= '0;
            seg_idx <= '0;
            nseg_r  <= nseg_clamp;
            if (nseg_clamp != '0) begin
              state <= LOAD;
              busy  <= 1'b1;
              s     <= seed;
              x_i   <= tbl_mode[0];
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            s     <= '0;
            x_i   <= 1'b0;
          end else begin
            state <= RUN;
            s     <= q;
            x_i   <= tbl_mode[seg_idx];
            cnt   <= '0;
          end
        end

        RUN: begin
          // abort wins over segment advance and leaves y_count untouched.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            s     <= '0;
            x_i   <= 1'b0;
          end else begin
            if (y) y_count <= y_next;
            if (seg_last && !more_segs) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              s     <= '0;
              x_i   <= 1'b0;
            end else if (seg_last) begin
              seg_idx <= next_idx;
              cnt     <= '0;
              s       <= q;
              x_i     <= tbl_mode[next_idx];
            end else begin
              cnt <= cnt + LENW'(1);
              s   <= q;
              x_i <= tbl_mode[seg_idx];
            end
          end
        end

        DONE: state <= IDLE;

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          s     <= '0;
          x_i   <= 1'b0;
        end
      endcase
    end
  end

endmodule
